comp_serial: RTL

Digit-serial magnitude comparator for sequential garbled-circuit synthesis. It generalises the combinational N-bit A >= B carry-chain comparator in three ways: it processes W bits per clock, it supports signed operands, and it evaluates six selectable relations. The datapath is a chain of W full adders computing A + ~B + carry, plus a running equality flag. It sits in the arithmetic library beside the adder, subtractor and comparator cells and is used wherever gate count matters more than latency.

---
 rtl/comp_serial_if.sv | 23 ++
 rtl/comp_serial.sv | 122 ++++++++++++
 2 files changed

// File: rtl/comp_serial_if.sv
// Handshake and operand bundle for the digit-serial comparator.
interface comp_serial_if #(
  parameter int N = 8
) ();
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   mode;
  logic         signed_cmp;
  logic         busy;
  logic         done;
  logic         O;

  modport master (
    output start, A, B, mode, signed_cmp,
    input  busy, done, O
  );

  modport slave (
    input  start, A, B, mode, signed_cmp,
    output busy, done, O
  );
endinterface

// File: rtl/comp_serial.sv
// Digit-serial comparator: W bits per cycle, LSB chunk first, carry chain of
// A + ~B + C plus a running equality flag; six selectable relations.
module comp_serial #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic          clk,
  input  logic          rst,
  comp_serial_if.slave  bus
);
  localparam int K  = (N + W - 1) / W;
  localparam int KW = K * W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   a_r, b_r, a_ld, b_ld, a_sh, b_sh;
  logic [2:0]      mode_r;
  logic            c_r, eq_r, o_r;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_c, b_c;
  logic [W:0]      add;
  logic            c_nx, eq_nx, last, accept, rel;

  // A new request is taken whenever no chunk is in flight.
  assign accept = bus.start && (state != RUN);
  assign last   = (cnt == CW'(K - 1));

  // Operand load: flipping the sign bit maps two's complement onto unsigned
  // order; the upper pad bits stay zero so they compare equal.
  always_comb begin
    a_ld = '0;
    b_ld = '0;
    a_ld[N-1:0] = bus.A;
    b_ld[N-1:0] = bus.B;
    if (bus.signed_cmp) begin
      a_ld[N-1] = ~bus.A[N-1];
      b_ld[N-1] = ~bus.B[N-1];
    end
  end

  // Operands shift right one chunk per RUN cycle; the low chunk is current.
  generate
    if (K > 1) begin : g_shift
      assign a_sh = {{W{1'b0}}, a_r[KW-1:W]};
      assign b_sh = {{W{1'b0}}, b_r[KW-1:W]};
    end else begin : g_noshift
      assign a_sh = '0;
      assign b_sh = '0;
    end
  endgenerate

  assign a_c   = a_r[W-1:0];
  assign b_c   = b_r[W-1:0];
  assign add   = {1'b0, a_c} + {1'b0, ~b_c} + {{W{1'b0}}, c_r};
  assign c_nx  = add[W];
  assign eq_nx = eq_r & (a_c == b_c);

  // Relation select from the carry/equality of the final chunk.
  always_comb begin
    rel = 1'b0;
    case (mode_r)
      3'b000:  rel = c_nx;
      3'b001:  rel = c_nx & ~eq_nx;
      3'b010:  rel = ~c_nx | eq_nx;
      3'b011:  rel = ~c_nx;
      3'b100:  rel = eq_nx;
      3'b101:  rel = ~eq_nx;
      default: rel = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: RUN for K cycles, one DONE cycle, which may restart directly.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load on accept, fold one chunk per RUN cycle, capture O on the
  // final chunk so it is valid on the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= '0;
      c_r    <= 1'b1;
      eq_r   <= 1'b1;
      cnt    <= '0;
      o_r    <= 1'b0;
    end else if (accept) begin
      a_r    <= a_ld;
      b_r    <= b_ld;
      mode_r <= bus.mode;
      c_r    <= 1'b1;
      eq_r   <= 1'b1;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_r  <= a_sh;
      b_r  <= b_sh;
      c_r  <= c_nx;
      eq_r <= eq_nx;
      cnt  <= cnt + 1'b1;
      if (last) o_r <= rel;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.O    = o_r;
endmodule
